// File: rtl/counter_pkg.sv
// Shared types for the counter-sequence checker.
//
// Contents:
//   checker_state_e - lock-acquisition state of count_checker
package counter_pkg;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,  // no reference value held yet
    ACQUIRE = 2'd1,  // reference held, counting consecutive +1 steps
    LOCKED  = 2'd2   // sequence confirmed, violations are reported
  } checker_state_e;

endpackage : counter_pkg

// File: rtl/count_checker.sv
// count_checker - sequence monitor for a free-running up-counter.
//
// Watches a counter's output on every valid cycle and confirms it advances by
// exactly +1 modulo 2^Width. After LockCycles consecutive correct steps it
// declares lock; while locked it reports increment violations (error),
// upstream restarts to zero (restart) and correct all-ones -> 0 wraps (wrap),
// and keeps a saturating tally of error pulses. All outputs are registered and
// reflect the valid sample taken on the previous clock edge.
//
// Parameters:
//   Width      - bit width of the observed count (>= 2)
//   LockCycles - consecutive correct increments required for lock (>= 1)
//   ErrWidth   - width of the saturating error tally
//
// Ports:
//   clk         in   clock
//   reset       in   synchronous, active-high reset
//   valid       in   count_in is sampled this cycle when high
//   count_in    in   observed counter value [Width]
//   locked      out  high while in LOCKED state
//   error       out  one-cycle pulse: increment violation while locked
//   restart     out  one-cycle pulse: value 0 broke the sequence while locked
//   wrap        out  one-cycle pulse: correct all-ones -> 0 step while locked
//   error_count out  saturating count of error pulses [ErrWidth]
module count_checker
  import counter_pkg::*;
#(
  parameter int Width      = 8,
  parameter int LockCycles = 4,
  parameter int ErrWidth   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                valid,
  input  logic [Width-1:0]    count_in,
  output logic                locked,
  output logic                error,
  output logic                restart,
  output logic                wrap,
  output logic [ErrWidth-1:0] error_count
);

  localparam int StreakW = $clog2(LockCycles + 1);
  localparam logic [StreakW-1:0] LockTarget = StreakW'(LockCycles);

  // ---------------------------------------------------------------------------
  // Registers and next-state values
  // ---------------------------------------------------------------------------
  checker_state_e      state_q, state_d;
  logic [Width-1:0]    prev_q, prev_d;
  logic [StreakW-1:0]  streak_q, streak_d;
  logic [ErrWidth-1:0] err_cnt_q, err_cnt_d;
  logic                error_q, error_d;
  logic                restart_q, restart_d;
  logic                wrap_q, wrap_d;

  // ---------------------------------------------------------------------------
  // Sample classification
  // ---------------------------------------------------------------------------
  logic [Width-1:0]   expected;
  logic               match;
  logic               count_zero;
  logic               prev_ones;
  logic               err_sat;
  logic [StreakW-1:0] streak_inc;

  // Truncation to Width bits gives the all-ones -> 0 wrap for free.
  assign expected   = prev_q + Width'(1);
  assign match      = (count_in == expected);
  assign count_zero = (count_in == '0);
  assign prev_ones  = &prev_q;
  assign err_sat    = &err_cnt_q;
  // streak_q never exceeds LockCycles-1, so the increment cannot overflow.
  assign streak_inc = streak_q + StreakW'(1);

  // ---------------------------------------------------------------------------
  // State register (single clocked process, synchronous reset)
  // ---------------------------------------------------------------------------
  // NOTE: every register is updated with <= so all of them sample the
  // pre-edge values together; blocking = here would chain the updates.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SEARCH;
      prev_q    <= '0;
      streak_q  <= '0;
      err_cnt_q <= '0;
      error_q   <= 1'b0;
      restart_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      streak_q  <= streak_d;
      err_cnt_q <= err_cnt_d;
      error_q   <= error_d;
      restart_q <= restart_d;
      wrap_q    <= wrap_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a hold default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    prev_d    = prev_q;
    streak_d  = streak_q;
    err_cnt_d = err_cnt_q;

    if (valid) begin
      unique case (state_q)
        SEARCH: begin
          prev_d   = count_in;
          streak_d = '0;
          state_d  = ACQUIRE;
        end

        ACQUIRE: begin
          prev_d = count_in;
          if (match) begin
            if (streak_inc == LockTarget) begin
              state_d  = LOCKED;
              streak_d = '0;
            end else begin
              streak_d = streak_inc;
            end
          end else begin
            // A bad step while acquiring only restarts the run; no report.
            streak_d = '0;
          end
        end

        LOCKED: begin
          prev_d = count_in;
          if (!match) begin
            state_d  = ACQUIRE;
            streak_d = '0;
            // A jump to zero is an upstream restart, not a counted error.
            if (!count_zero && !err_sat) begin
              err_cnt_d = err_cnt_q + ErrWidth'(1);
            end
          end
        end

        default: begin
          // Unused encoding: fall back to a clean search.
          state_d  = SEARCH;
          streak_d = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic (pulses are registered one cycle after the sample)
  // ---------------------------------------------------------------------------
  always_comb begin
    error_d   = 1'b0;
    restart_d = 1'b0;
    wrap_d    = 1'b0;

    if (valid && (state_q == LOCKED)) begin
      error_d   = !match && !count_zero;
      restart_d = !match &&  count_zero;
      wrap_d    =  match &&  prev_ones;
    end
  end

  // locked is a decode of the registered state, so it drops on the same edge
  // that launches an error or restart pulse.
  assign locked      = (state_q == LOCKED);
  assign error       = error_q;
  assign restart     = restart_q;
  assign wrap        = wrap_q;
  assign error_count = err_cnt_q;

endmodule : count_checker
